// File: rtl/rempty_fwft_if.sv
// Read-side bundle of an async FIFO with a first-word-fall-through output stage.
// slave is the read-pointer/output block; master is the memory plus consumer side.
interface rempty_fwft_if #(
    parameter int depth  = 8,
    parameter int n      = $clog2(depth),
    parameter int dwidth = 8
);
    logic [n:0]        rq2_wptr;
    logic [dwidth-1:0] rdata;
    logic              dout_ready;
    logic [n-1:0]      raddr;
    logic [n:0]        rptr;
    logic              rempty;
    logic [dwidth-1:0] dout;
    logic              dout_valid;
    logic [n:0]        rcount;

    modport slave (
        input  rq2_wptr, rdata, dout_ready,
        output raddr, rptr, rempty, dout, dout_valid, rcount
    );

    modport master (
        output rq2_wptr, rdata, dout_ready,
        input  raddr, rptr, rempty, dout, dout_valid, rcount
    );
endinterface

// File: rtl/rempty_fwft.sv
// Read-domain pointer logic of an async FIFO: synchronizes the Gray write pointer,
// keeps the binary/Gray read pointer and pre-fetches into a FWFT output register.
module rempty_fwft #(
    parameter int depth  = 8,
    parameter int n      = $clog2(depth),
    parameter int dwidth = 8
) (
    input  logic         rclk,
    input  logic         rrst_n,
    rempty_fwft_if.slave bus
);
    logic [n:0]        rbin;
    logic [n:0]        sync0;
    logic [n:0]        sync1;
    logic [n:0]        rptr_int;
    logic [n:0]        wbin_sync;
    logic [dwidth-1:0] dout_q;
    logic              dout_valid_q;
    logic              rempty_int;
    logic              fetch;

    assign rptr_int   = (rbin >> 1) ^ rbin;
    assign rempty_int = (rptr_int == sync1);
    assign fetch      = !rempty_int && (!dout_valid_q || bus.dout_ready);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin_sync = '0;
        for (int i = 0; i <= n; i++) begin
            wbin_sync[i] = ^(sync1 >> i);
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= bus.rq2_wptr;
            sync1 <= sync0;
        end
    end

    // A fetch refills the output register even while its current word is being
    // accepted, so a ready consumer sees one word per cycle.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (fetch) begin
            rbin         <= rbin + (n+1)'(1);
            dout_q       <= bus.rdata;
            dout_valid_q <= 1'b1;
        end else if (dout_valid_q && bus.dout_ready) begin
            dout_valid_q <= 1'b0;
        end
    end

    assign bus.raddr      = rbin[n-1:0];
    assign bus.rptr       = rptr_int;
    assign bus.rempty     = rempty_int;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.rcount     = wbin_sync - rbin;
endmodule

// File: tb/tb_rempty_fwft.sv
// Directed bench for rempty_fwft: a memory model plus a queue of words written
// on the write side, compared against dout whenever the consumer accepts one.
module tb_rempty_fwft;
    logic rclk;
    logic rrst_n;
    int   checks;
    int   failures;

    logic [7:0] mem [0:7];
    logic [3:0] wbin;
    logic [7:0] sb [$];

    rempty_fwft_if #(.depth(8), .dwidth(8)) bus ();

    rempty_fwft #(.depth(8), .dwidth(8)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    assign bus.rdata = mem[bus.raddr];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then back to the falling edge where outputs are sampled.
    task automatic step();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wbin[2:0]] = d;
        wbin = wbin + 4'd1;
        bus.rq2_wptr = bin2gray(wbin);
        sb.push_back(d);
    endtask

    task automatic drain(input string tag, input int budget);
        int cyc;
        logic [7:0] exp;
        cyc = 0;
        bus.dout_ready = 1'b1;
        while (sb.size() > 0 && cyc < budget) begin
            if (bus.dout_valid) begin
                exp = sb.pop_front();
                check(tag, bus.dout, exp);
            end
            check({tag, "_rcount_max"}, bus.rcount <= 4'd8, 1);
            step();
            cyc++;
        end
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    task automatic reset_pulse();
        rrst_n = 1'b0;
        wbin = '0;
        bus.rq2_wptr = '0;
        sb.delete();
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rrst_n = 1'b0;
        wbin = '0;
        bus.rq2_wptr = '0;
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        repeat (2) @(negedge rclk);

        check("rst_raddr", bus.raddr, 0);
        check("rst_rptr", bus.rptr, 0);
        check("rst_rempty", bus.rempty, 1);
        check("rst_rcount", bus.rcount, 0);
        check("rst_dout_valid", bus.dout_valid, 0);

        // Single word with no consumer: three-edge latency, then held.
        rrst_n = 1'b1;
        write_word(8'hA5);
        mem[1] = 8'h3C;
        step();
        step();
        check("lat_dv_edge2", bus.dout_valid, 0);
        check("lat_rempty_edge2", bus.rempty, 0);
        check("lat_rcount_edge2", bus.rcount, 1);
        step();
        check("lat_dv_edge3", bus.dout_valid, 1);
        check("lat_dout_edge3", bus.dout, sb[0]);
        check("lat_raddr", bus.raddr, 1);
        check("lat_rptr", bus.rptr, 4'b0001);
        check("lat_rempty", bus.rempty, 1);
        repeat (3) step();
        check("hold_dout", bus.dout, sb[0]);
        check("hold_dv", bus.dout_valid, 1);
        check("hold_raddr", bus.raddr, 1);
        bus.dout_ready = 1'b1;
        check("a5_accept", bus.dout, sb.pop_front());
        step();
        check("a5_dv_cleared", bus.dout_valid, 0);
        bus.dout_ready = 1'b0;

        // Asynchronous reset while a word is held, between clock edges.
        write_word(8'h5A);
        repeat (3) step();
        check("mid_dv_before", bus.dout_valid, 1);
        check("mid_dout_before", bus.dout, sb[0]);
        #2;
        rrst_n = 1'b0;
        #1;
        check("arst_dv", bus.dout_valid, 0);
        check("arst_raddr", bus.raddr, 0);
        check("arst_rptr", bus.rptr, 0);
        check("arst_rempty", bus.rempty, 1);
        check("arst_rcount", bus.rcount, 0);
        wbin = '0;
        bus.rq2_wptr = '0;
        sb.delete();
        @(negedge rclk);
        rrst_n = 1'b1;

        // Full burst of depth words streamed out on consecutive cycles.
        bus.dout_ready = 1'b1;
        for (int k = 0; k < 8; k++) write_word(8'h10 + 8'(k));
        step();
        step();
        check("burst_rcount_full", bus.rcount, 8);
        check("burst_dv_idle", bus.dout_valid, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("burst_dv", bus.dout_valid, 1);
            check("burst_dout", bus.dout, sb.pop_front());
        end
        step();
        check("burst_dv_end", bus.dout_valid, 0);
        check("burst_rempty_end", bus.rempty, 1);
        check("burst_rcount_end", bus.rcount, 0);
        check("burst_rptr_end", bus.rptr, 4'b1100);
        bus.dout_ready = 1'b0;

        // Backpressure: output and read pointer frozen while unread words wait.
        bus.dout_ready = 1'b0;
        write_word(8'hC1);
        write_word(8'hC2);
        write_word(8'hC3);
        repeat (3) step();
        check("bp_dv", bus.dout_valid, 1);
        check("bp_dout_first", bus.dout, sb[0]);
        check("bp_rempty", bus.rempty, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_dout_hold", bus.dout, sb[0]);
            check("bp_raddr_hold", bus.raddr, 1);
            check("bp_rptr_hold", bus.rptr, 4'b1101);
        end
        drain("bp_drain", 20);
        check("bp_rptr_end", bus.rptr, bin2gray(wbin));

        // Pointer wrap: 16 words in two batches, then 4 more past the wrap.
        bus.dout_ready = 1'b0;
        reset_pulse();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 8; k++) write_word(8'($urandom_range(0, 255)));
            drain("wrap_batch", 30);
        end
        check("wrap_rptr_zero", bus.rptr, 4'b0000);
        check("wrap_raddr_zero", bus.raddr, 0);
        check("wrap_rempty", bus.rempty, 1);
        for (int k = 0; k < 4; k++) write_word(8'hE0 + 8'(k));
        check("wrap_wptr_gray4", bus.rq2_wptr, 4'b0110);
        drain("wrap_tail", 20);
        check("wrap_rptr_tail", bus.rptr, 4'b0110);
        check("wrap_raddr_tail", bus.raddr, 4);
        check("wrap_rcount_tail", bus.rcount, 0);

        // Ready asserted on an empty FIFO changes nothing.
        bus.dout_ready = 1'b1;
        repeat (3) step();
        check("idle_ready_dv", bus.dout_valid, 0);
        check("idle_ready_rptr", bus.rptr, 4'b0110);
        bus.dout_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
